// File: rtl/control_sequencer_pkg.sv
// Shared LEGv8 sequencer definitions: control-word field positions,
// sequencer state encoding and micro-state constants.
package legv8_ctrl_pkg;

  localparam int CW_W    = 31;
  localparam int PSEL_HI = 30;
  localparam int PSEL_LO = 29;
  localparam int DA_HI   = 28;
  localparam int DA_LO   = 24;
  localparam int SA_HI   = 23;
  localparam int SA_LO   = 19;
  localparam int SB_HI   = 18;
  localparam int SB_LO   = 14;
  localparam int FSEL_HI = 13;
  localparam int FSEL_LO = 9;
  localparam int REGW    = 8;
  localparam int RAMW    = 7;
  localparam int EN_MEM  = 6;
  localparam int EN_ALU  = 5;
  localparam int EN_B    = 4;
  localparam int EN_PC   = 3;
  localparam int BSEL    = 2;
  localparam int PCSEL   = 1;
  localparam int SL      = 0;

  // Psel=00 holds PC; nothing writes, nothing drives the bus.
  localparam logic [CW_W-1:0] CW_NOP = '0;

  // Decoder micro-state meaning "this instruction is finished".
  localparam logic [1:0] ST_DONE = 2'b00;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_FETCH = 2'd1,
    SEQ_EXEC  = 2'd2,
    SEQ_HALT  = 2'd3
  } seq_state_t;

  // A step touching data memory (read enable or RAM write) must wait for mem_ready.
  function automatic logic is_mem_step(input logic [CW_W-1:0] cw);
    return cw[EN_MEM] | cw[RAMW];
  endfunction

  // While stalled, PC must not advance and no register may be written.
  function automatic logic [CW_W-1:0] stall_mask(input logic [CW_W-1:0] cw);
    logic [CW_W-1:0] m;
    m = cw;
    m[PSEL_HI:PSEL_LO] = 2'b00;
    m[REGW] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer, instruction/data memory, decoder mux and datapath.
interface control_sequencer_if;
  import legv8_ctrl_pkg::*;

  logic            start;
  logic            halt_req;
  logic [31:0]     instruction;
  logic            mem_ready;
  logic [CW_W-1:0] dec_controlWord;
  logic [1:0]      dec_nextState;
  logic [63:0]     dec_K;

  logic [31:0]     IR;
  logic [1:0]      state;
  logic [CW_W-1:0] controlWord;
  logic [63:0]     K;
  logic            mem_req;
  logic            halted;
  logic            fault;
  logic [31:0]     retired;

  modport master (
    output start, halt_req, instruction, mem_ready,
           dec_controlWord, dec_nextState, dec_K,
    input  IR, state, controlWord, K, mem_req, halted, fault, retired
  );

  modport slave (
    input  start, halt_req, instruction, mem_ready,
           dec_controlWord, dec_nextState, dec_K,
    output IR, state, controlWord, K, mem_req, halted, fault, retired
  );
endinterface

// File: rtl/control_sequencer.sv
// LEGv8 multi-cycle fetch/execute sequencer: owns IR and the decoder
// micro-state, gates the decoder's control word onto the datapath, stalls
// memory steps on mem_ready, counts retirements and faults runaway instructions.
module control_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int MAX_STEPS = 4
) (
  input logic                clock,
  input logic                reset,
  control_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MAX_STEPS - 1);

  seq_state_t      seq;
  logic [31:0]     ir;
  logic [1:0]      ustate;
  logic [CNT_W-1:0] step_cnt;
  logic            fault;
  logic [31:0]     retired;

  logic [CW_W-1:0] cw;
  logic [63:0]     k;
  logic            mem_step;
  logic            commit;

  // Datapath drive: NOP outside EXEC, decoder word in EXEC, masked while stalled.
  always_comb begin
    cw       = CW_NOP;
    k        = '0;
    mem_step = 1'b0;
    commit   = 1'b0;
    if (seq == SEQ_EXEC) begin
      mem_step = is_mem_step(bus.dec_controlWord);
      commit   = ~mem_step | bus.mem_ready;
      cw       = commit ? bus.dec_controlWord : stall_mask(bus.dec_controlWord);
      k        = bus.dec_K;
    end
  end

  // Sequencer FSM with IR, micro-state, step limit and retirement counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq      <= SEQ_IDLE;
      ir       <= '0;
      ustate   <= ST_DONE;
      step_cnt <= '0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      unique case (seq)
        SEQ_IDLE: begin
          if (bus.start) seq <= SEQ_FETCH;
        end
        SEQ_FETCH: begin
          ir       <= bus.instruction;
          ustate   <= ST_DONE;
          step_cnt <= '0;
          seq      <= SEQ_EXEC;
        end
        SEQ_EXEC: begin
          if (commit) begin
            step_cnt <= step_cnt + 1'b1;
            ustate   <= bus.dec_nextState;
            if (bus.dec_nextState == ST_DONE) begin
              retired <= retired + 32'd1;
              seq     <= bus.halt_req ? SEQ_HALT : SEQ_FETCH;
            end else if (step_cnt == LAST_STEP) begin
              fault <= 1'b1;
              seq   <= SEQ_HALT;
            end
          end
        end
        SEQ_HALT: begin
          seq <= SEQ_HALT;
        end
        default: begin
          seq <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign bus.IR          = ir;
  assign bus.state       = ustate;
  assign bus.controlWord = cw;
  assign bus.K           = k;
  assign bus.mem_req     = mem_step;
  assign bus.halted      = (seq == SEQ_HALT);
  assign bus.fault       = fault;
  assign bus.retired     = retired;

endmodule
